mix_out_collect: RTL

MIX_OUT_COLLECT -- requirements
Module: mix_out_collect

---
 rtl/mix_out_collect_pkg.sv | 20 ++
 rtl/mix_out_collect.sv | 139 +++++++++++++
 2 files changed

// File: rtl/mix_out_collect_pkg.sv
// ----------------------------------------------------------------------------
// mix_out_collect_pkg
//   Shared geometry constants for the mix-output collector and a helper that
//   derives the number of input beats per output frame.
//   HID_DIM : output vector length in elements
//   DATA_N  : elements delivered per input beat
//   N_LEN   : bits per element
// ----------------------------------------------------------------------------
package mix_out_collect_pkg;

    localparam int unsigned HID_DIM = 24;
    localparam int unsigned DATA_N  = 8;
    localparam int unsigned N_LEN   = 16;

    function automatic int unsigned beats_of(input int unsigned hid,
                                             input int unsigned chunk);
        return hid / chunk;
    endfunction

endpackage

// File: rtl/mix_out_collect.sv
// ----------------------------------------------------------------------------
// mix_out_collect
//   Assembles HID-element output vectors from a stream of CHUNK-element beats.
//   Beats are written into an assembly buffer slot by slot; when the last slot
//   is written the whole buffer is published on data_out together with a
//   one-cycle valid pulse. Partial frames never reach data_out.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   run      : frame enable; low aborts a partial frame / idles the block
//   in_valid : data_in carries a beat this cycle
//   data_in  : CHUNK*NL bits, element 0 in LSBs
//   valid    : one-cycle pulse, data_out holds a new complete frame
//   busy     : a frame is partially collected
//   ovf      : sticky, a beat arrived while the block could not accept it
//   data_out : HID*NL bits, assembled vector, element 0 in LSBs
// ----------------------------------------------------------------------------
module mix_out_collect
    import mix_out_collect_pkg::*;
#(
    parameter int unsigned HID   = HID_DIM,
    parameter int unsigned CHUNK = DATA_N,
    parameter int unsigned NL    = N_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  in_valid,
    input  logic [CHUNK*NL-1:0]   data_in,
    output logic                  valid,
    output logic                  busy,
    output logic                  ovf,
    output logic [HID*NL-1:0]     data_out
);

    localparam int unsigned BEATS = beats_of(HID, CHUNK);
    localparam int unsigned BW    = CHUNK * NL;
    localparam int unsigned FW    = HID * NL;
    localparam int unsigned CW    = $clog2(BEATS + 1);

    generate
        if ((HID % CHUNK) != 0) begin : g_bad_geometry
            $error("mix_out_collect: HID (%0d) must be a multiple of CHUNK (%0d)", HID, CHUNK);
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [FW-1:0]   r_buf;
    logic [FW-1:0]   w_merged;
    logic            w_last;

    // Buffer as it looks once the current beat lands in slot r_cnt. Used both
    // for the buffer update and, on the final beat, for data_out, so the frame
    // published is complete in the same edge that enters DONE.
    always_comb begin
        w_merged = r_buf;
        for (int unsigned k = 0; k < BEATS; k++) begin
            if (32'(r_cnt) == k) begin
                w_merged[k*BW +: BW] = data_in;
            end
        end
        w_last = (32'(r_cnt) == (BEATS - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_buf    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            ovf      <= 1'b0;
            data_out <= '0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (run && in_valid) begin
                        r_buf <= w_merged;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state  <= S_DONE;
                            valid    <= 1'b1;
                            data_out <= w_merged;
                        end else begin
                            r_state <= S_COLLECT;
                            busy    <= 1'b1;
                        end
                    end else if (!run) begin
                        // Idle with run low ends the session: start clean.
                        ovf <= 1'b0;
                    end
                end

                S_COLLECT: begin
                    if (!run) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else if (in_valid) begin
                        r_buf <= w_merged;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_state  <= S_DONE;
                            busy     <= 1'b0;
                            valid    <= 1'b1;
                            data_out <= w_merged;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                    if (in_valid) begin
                        ovf <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
